// File: rtl/ps_acp_rd_master.sv
// AXI3 read master for the PS ACP port: splits a (address, beat count) command into
// 4 KB-safe INCR bursts and streams the returned 64-bit data out through one register.
module ps_acp_rd_master #(
  parameter logic [3:0]  ARCACHE   = 4'b1111,
  parameter logic [4:0]  ARUSER    = 5'b00001,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [15:0] cmd_beats,
  output logic [31:0] S_AXI_ACP_0_araddr,
  output logic [1:0]  S_AXI_ACP_0_arburst,
  output logic [3:0]  S_AXI_ACP_0_arcache,
  output logic [2:0]  S_AXI_ACP_0_arid,
  output logic [3:0]  S_AXI_ACP_0_arlen,
  output logic [1:0]  S_AXI_ACP_0_arlock,
  output logic [2:0]  S_AXI_ACP_0_arprot,
  output logic [3:0]  S_AXI_ACP_0_arqos,
  output logic [2:0]  S_AXI_ACP_0_arsize,
  output logic [4:0]  S_AXI_ACP_0_aruser,
  output logic        S_AXI_ACP_0_arvalid,
  input  logic        S_AXI_ACP_0_arready,
  input  logic [63:0] S_AXI_ACP_0_rdata,
  input  logic [2:0]  S_AXI_ACP_0_rid,
  input  logic        S_AXI_ACP_0_rlast,
  input  logic [1:0]  S_AXI_ACP_0_rresp,
  input  logic        S_AXI_ACP_0_rvalid,
  output logic        S_AXI_ACP_0_rready,
  output logic [63:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 16;
  localparam int unsigned LW = 5;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_FLUSH} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, araddr_q, araddr_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [3:0]    arlen_q, arlen_d;
  logic          arvalid_q, arvalid_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          cmd_ready_q, cmd_ready_d;

  logic [9:0]    bnd_c;
  logic [LW-1:0] len_c, burst_len_c;
  logic          rready_c;
  logic          unused_c;

  // Beats left before the next 4 KB page boundary (1..512).
  assign bnd_c = 10'((13'd4096 - {1'b0, addr_q[11:0]}) >> 3);

  // Burst length: min(remaining, MAX_BURST, beats to page boundary).
  always_comb begin
    len_c = LW'(MAX_BURST);
    if (rem_q < CW'(MAX_BURST)) len_c = LW'(rem_q);
    if (bnd_c < 10'(len_c))     len_c = LW'(bnd_c);
  end

  assign burst_len_c = {1'b0, arlen_q} + 5'd1;
  assign rready_c    = (state_q == S_DATA) && (!m_valid_q || m_ready);
  assign unused_c    = ^S_AXI_ACP_0_rid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arvalid_q   <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arvalid_q   <= arvalid_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arvalid_d   = arvalid_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    cmd_ready_d = 1'b0;

    // Downstream unload; a load in DATA below overrides it.
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = {cmd_addr[31:3], 3'b000};
          rem_d       = cmd_beats;
          err_d       = 1'b0;
          if (cmd_beats == '0) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            busy_d  = 1'b1;
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (!arvalid_q) begin
          arvalid_d = 1'b1;
          araddr_d  = addr_q;
          arlen_d   = 4'(len_c - 5'd1);
        end else if (S_AXI_ACP_0_arready) begin
          arvalid_d = 1'b0;
          addr_d    = addr_q + {24'b0, burst_len_c, 3'b000};
          rem_d     = rem_q - CW'(burst_len_c);
          cnt_d     = burst_len_c;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (S_AXI_ACP_0_rvalid && rready_c) begin
          m_data_d  = S_AXI_ACP_0_rdata;
          m_valid_d = 1'b1;
          m_last_d  = (cnt_q == 5'd1) && (rem_q == '0);
          if ((S_AXI_ACP_0_rresp != 2'b00) || (S_AXI_ACP_0_rlast != (cnt_q == 5'd1))) err_d = 1'b1;
          cnt_d = cnt_q - 5'd1;
          // Our own beat count, not rlast, closes the burst.
          if (cnt_q == 5'd1) state_d = (rem_q != '0) ? S_ADDR : S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (m_valid_q && m_ready && m_last_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready           = cmd_ready_q;
  assign S_AXI_ACP_0_araddr  = araddr_q;
  assign S_AXI_ACP_0_arlen   = arlen_q;
  assign S_AXI_ACP_0_arvalid = arvalid_q;
  assign S_AXI_ACP_0_arburst = 2'b01;
  assign S_AXI_ACP_0_arsize  = 3'b011;
  assign S_AXI_ACP_0_arid    = 3'b000;
  assign S_AXI_ACP_0_arlock  = 2'b00;
  assign S_AXI_ACP_0_arprot  = 3'b000;
  assign S_AXI_ACP_0_arqos   = 4'b0000;
  assign S_AXI_ACP_0_arcache = ARCACHE;
  assign S_AXI_ACP_0_aruser  = ARUSER;
  assign S_AXI_ACP_0_rready  = rready_c;
  assign m_data              = m_data_q;
  assign m_valid             = m_valid_q;
  assign m_last              = m_last_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign err                 = err_q;

endmodule

// File: tb/tb_ps_acp_rd_master.sv
// Bench for ps_acp_rd_master: a behavioural AXI read slave plus a burst-split/data model.
module tb_ps_acp_rd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic [31:0] araddr;
  logic [1:0]  arburst, arlock, rresp;
  logic [3:0]  arcache, arlen, arqos;
  logic [2:0]  arid, arprot, arsize, rid;
  logic [4:0]  aruser;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [63:0] rdata, m_data;
  logic        m_valid, m_ready, m_last, busy, done, err;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct { logic [31:0] a; logic [3:0] l; } ar_t;

  always #5 clk = ~clk;

  ps_acp_rd_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .S_AXI_ACP_0_araddr(araddr), .S_AXI_ACP_0_arburst(arburst), .S_AXI_ACP_0_arcache(arcache),
    .S_AXI_ACP_0_arid(arid), .S_AXI_ACP_0_arlen(arlen), .S_AXI_ACP_0_arlock(arlock),
    .S_AXI_ACP_0_arprot(arprot), .S_AXI_ACP_0_arqos(arqos), .S_AXI_ACP_0_arsize(arsize),
    .S_AXI_ACP_0_aruser(aruser), .S_AXI_ACP_0_arvalid(arvalid), .S_AXI_ACP_0_arready(arready),
    .S_AXI_ACP_0_rdata(rdata), .S_AXI_ACP_0_rid(rid), .S_AXI_ACP_0_rlast(rlast),
    .S_AXI_ACP_0_rresp(rresp), .S_AXI_ACP_0_rvalid(rvalid), .S_AXI_ACP_0_rready(rready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done), .err(err)
  );

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  // Runs one command end to end. mr_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  // rv_mode: 0 rvalid whenever a burst is open, 1 random. err_beat: 0-based beat given rresp=2'b10.
  // abort_after > 0 pulls reset after that many R beats and checks the reset values.
  task automatic run_cmd(input logic [31:0] addr, input int beats, input int mr_mode,
                         input int rv_mode, input int err_beat, input bit bad_rlast,
                         input int abort_after);
    ar_t exp_ar[$];
    ar_t e;
    logic [31:0] a, base, s_addr, cap_araddr, pv_addr;
    logic [63:0] cap_data;
    logic [3:0]  cap_arlen, pv_len;
    logic        cap_last;
    int rem, len, bnd, s_len, s_idx, r_total, m_count, ar_count, n_bursts, done_at;
    bit cmd_pend, cmd_hs, ar_hs, r_hs, m_hs, s_active, pv_pend, exp_err;

    a = {addr[31:3], 3'b000};
    base = a;
    rem = beats;
    while (rem > 0) begin
      bnd = (4096 - int'(a[11:0])) / 8;
      len = (rem < 16) ? rem : 16;
      if (bnd < len) len = bnd;
      e.a = a;
      e.l = 4'(len - 1);
      exp_ar.push_back(e);
      a = a + 32'(len * 8);
      rem -= len;
    end
    n_bursts = exp_ar.size();
    exp_err = ((err_beat >= 0) && (err_beat < beats)) || (bad_rlast && beats > 0);

    cmd_pend = 1; cmd_hs = 0; ar_hs = 0; r_hs = 0; m_hs = 0; s_active = 0; pv_pend = 0;
    s_len = 0; s_idx = 0; r_total = 0; m_count = 0; ar_count = 0; done_at = -1;
    s_addr = '0; cap_araddr = '0; cap_arlen = '0; cap_data = '0; cap_last = 0;
    pv_addr = '0; pv_len = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cmd_hs) begin
        cmd_pend = 0;
        n_assert++;
        if (err !== 1'b0 || busy !== (beats != 0)) begin
          n_fail++;
          $display("FAIL cmd_accept: err=%b busy=%b, required err=0 busy=%b", err, busy, beats != 0);
        end
      end
      if (pv_pend) begin
        n_assert++;
        if (arvalid !== 1'b1 || araddr !== pv_addr || arlen !== pv_len) begin
          n_fail++;
          $display("FAIL ar_stable: arvalid=%b araddr=%h arlen=%0d, required 1 %h %0d",
                   arvalid, araddr, arlen, pv_addr, pv_len);
        end
      end
      if (ar_hs) begin
        ar_count++;
        n_assert++;
        if (exp_ar.size() == 0 || s_active) begin
          n_fail++;
          $display("FAIL ar_unexpected: araddr=%h arlen=%0d, required none (open=%b)", cap_araddr, cap_arlen, s_active);
        end else begin
          e = exp_ar.pop_front();
          if (cap_araddr !== e.a || cap_arlen !== e.l) begin
            n_fail++;
            $display("FAIL ar_fields: araddr=%h arlen=%0d, required %h %0d", cap_araddr, cap_arlen, e.a, e.l);
          end
        end
        n_assert++;
        if ({arburst, arsize, arid, arlock, arprot, arqos, arcache, aruser} !== {2'b01, 3'b011, 3'd0, 2'd0, 3'd0, 4'd0, 4'b1111, 5'b00001}) begin
          n_fail++;
          $display("FAIL ar_const: burst=%b size=%b id=%0d lock=%0d prot=%0d qos=%0d cache=%b user=%b, required 01 011 0 0 0 0 1111 00001",
                   arburst, arsize, arid, arlock, arprot, arqos, arcache, aruser);
        end
        s_active = 1; s_addr = cap_araddr; s_len = int'(cap_arlen) + 1; s_idx = 0;
      end
      if (r_hs) begin
        s_idx++;
        r_total++;
        if (s_idx == s_len) s_active = 0;
        if (abort_after > 0 && r_total == abort_after) begin
          #1 rst = 1'b0;
          #1;
          n_assert++;
          if ({cmd_ready, arvalid, m_valid, m_last, busy, done, err, araddr, arlen, m_data} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_vals: rdy=%b arv=%b mv=%b ml=%b busy=%b done=%b err=%b araddr=%h arlen=%0d m_data=%h, required all 0",
                     cmd_ready, arvalid, m_valid, m_last, busy, done, err, araddr, arlen, m_data);
          end
          cmd_valid = 0; rvalid = 0; rlast = 0; arready = 0; m_ready = 1;
          repeat (2) @(negedge clk);
          rst = 1'b1;
          @(negedge clk);
          return;
        end
      end
      if (m_hs) begin
        n_assert++;
        if (cap_data !== mem_word(base + 32'(m_count * 8)) || cap_last !== (m_count == beats - 1)) begin
          n_fail++;
          $display("FAIL m_beat%0d: data=%h last=%b, required %h %b", m_count, cap_data, cap_last,
                   mem_word(base + 32'(m_count * 8)), m_count == beats - 1);
        end
        m_count++;
      end
      if (done_at >= 0) begin
        n_assert++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL after_done: done=%b cmd_ready=%b, required 0 1", done, cmd_ready);
        end
        return;
      end
      if (done === 1'b1) begin
        done_at = cyc;
        n_assert++;
        if (busy !== 1'b0 || m_count != beats || ar_count != n_bursts || err !== exp_err || cmd_hs == 0 && cmd_pend) begin
          n_fail++;
          $display("FAIL at_done: busy=%b beats=%0d ars=%0d err=%b, required 0 %0d %0d %b",
                   busy, m_count, ar_count, err, beats, n_bursts, exp_err);
        end
      end

      cmd_valid = cmd_pend;
      cmd_addr  = addr;
      cmd_beats = 16'(beats);
      arready   = 1'($urandom_range(0, 1));
      rid       = 3'($urandom_range(0, 7));
      if (s_active && (rv_mode == 0 || $urandom_range(0, 1) == 1)) begin
        rvalid = 1;
        rdata  = mem_word(s_addr + 32'(s_idx * 8));
        rlast  = bad_rlast ? 1'b0 : (s_idx == s_len - 1);
        rresp  = (r_total == err_beat) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 0;
        rdata  = {$urandom, $urandom};
        rlast  = 1'($urandom_range(0, 1));
        rresp  = 2'b00;
      end
      case (mr_mode)
        0:       m_ready = 1;
        1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase

      #1;
      cmd_hs     = cmd_valid && cmd_ready;
      ar_hs      = arvalid && arready;
      pv_pend    = arvalid && !arready;
      pv_addr    = araddr;
      pv_len     = arlen;
      cap_araddr = araddr;
      cap_arlen  = arlen;
      r_hs       = rvalid && rready;
      m_hs       = m_valid && m_ready;
      cap_data   = m_data;
      cap_last   = m_last;
      if (m_valid && !m_ready) begin
        n_assert++;
        if (rready !== 1'b0) begin
          n_fail++;
          $display("FAIL rready_hold: rready=%b with m_valid=1 m_ready=0, required 0", rready);
        end
      end
    end
    n_assert++;
    n_fail++;
    $display("FAIL timeout: beats delivered=%0d done_seen=%0d, required %0d 1", m_count, done_at >= 0, beats);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cmd_valid = 0; cmd_addr = '0; cmd_beats = '0; arready = 0; rvalid = 0; rdata = '0;
    rid = '0; rlast = 0; rresp = '0; m_ready = 1;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({cmd_ready, arvalid, m_valid, m_last, busy, done, err, araddr, arlen, m_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_vals: rdy=%b arv=%b mv=%b ml=%b busy=%b done=%b err=%b, required all 0",
               cmd_ready, arvalid, m_valid, m_last, busy, done, err);
    end
    rst = 1'b1;
    #1;
    n_assert++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: cmd_ready=%b, required 0", cmd_ready);
    end
    @(negedge clk);
    n_assert++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_edge: cmd_ready=%b, required 1", cmd_ready);
    end
  endtask

  task automatic test_single();       run_cmd(32'h1000_0000, 1, 0, 0, -1, 0, 0);  endtask
  task automatic test_multi_burst();  run_cmd(32'h1000_0000, 40, 0, 0, -1, 0, 0); endtask
  task automatic test_4k_cross();     run_cmd(32'h0000_0FC5, 20, 2, 1, -1, 0, 0); endtask
  task automatic test_backpressure(); run_cmd(32'h2000_0040, 16, 1, 0, -1, 0, 0); endtask
  task automatic test_zero_beats();   run_cmd(32'h3000_0000, 0, 0, 0, -1, 0, 0);  endtask
  task automatic test_rlast_mismatch(); run_cmd(32'h4000_0008, 5, 0, 1, -1, 1, 0); endtask

  task automatic test_rresp_err();
    run_cmd(32'h1234_5670, 8, 2, 1, 2, 0, 0);
    run_cmd(32'h1234_6000, 3, 0, 0, -1, 0, 0);
  endtask

  task automatic test_mid_reset();
    run_cmd(32'h5000_0000, 16, 0, 0, -1, 0, 5);
    run_cmd(32'h5000_0100, 16, 0, 0, -1, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 12; i++) begin
      a = {$urandom_range(0, 15), 16'h0, 4'($urandom_range(0, 15)), 8'($urandom)};
      run_cmd(a, $urandom_range(0, 70), $urandom_range(0, 2), $urandom_range(0, 1),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_burst();
    test_4k_cross();
    test_backpressure();
    test_rresp_err();
    test_mid_reset();
    test_zero_beats();
    test_rlast_mismatch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
